pcm_i2s_tx: RTL and testbench
=============================

# pcm_i2s_tx

Downstream output stage for the ADPCM voice engine. It accepts the signed 21-bit mixed sample and its one-cycle sample strobe, then scales and saturates it to 16 bits. The result is buffered in a small FIFO and serialised as a stereo I2S stream, with the mono sample duplicated to both channels. It decouples the voice engine's sample-rate counter from the DAC's frame clock and reports overflow and underflow.

## Interface
- BCLK_DIV, 4: CLK cycles per BCLK half-period, ≥1; frame = 64·BCLK_DIV CLK cycles.
- FIFO_DEPTH, 4: sample FIFO entries, power of two, ≥2.
- SHIFT, 4: arithmetic right shift applied to SAMP_IN before saturation, 0..5.
- CLK  in  1  system clock.
- RESET_N  in  1  asynchronous, active-low reset.
- SAMP_IN  in  21  signed sample from voice engine.
- SAMP_VALID  in  1  one-cycle strobe, SAMP_IN valid.
- MUTE  in  1  forces transmitted words to 0; FIFO still pops.
- CLR_FLAGS  in  1  clears sticky flags.
- I2S_BCLK  out  1  bit clock.
- I2S_LRCK  out  1  word select, 0 = left.
- I2S_DATA  out  1  serial data, MSB first.
- FIFO_LEVEL  out  $clog2(FIFO_DEPTH)+1  current occupancy.
- OVERFLOW  out  1  sticky, sample dropped.
- UNDERFLOW  out  1  sticky, frame started with FIFO empty after priming.

## Operation
- Ingest: on SAMP_VALID, x = SAMP_IN >>> SHIFT.
  - x is saturated to [-32768, 32767] and written to the FIFO.
  - If the FIFO is full, the sample is dropped and OVERFLOW is set.
- PRIMED is set by the first accepted write and cleared only by reset.
- Divider DIV_CNT counts BCLK_DIV-1 down to 0. At 0 it reloads and issues a tick; each tick toggles I2S_BCLK.
- On each falling tick (BCLK 1→0), BIT_IDX advances modulo 32. Let b be the new value; the following act on that same edge:
  - b==0:
    - If the FIFO is non-empty, pop it into CUR.
    - If it is empty and PRIMED, CUR holds and UNDERFLOW is set.
    - If it is empty and not PRIMED, CUR = 0.
    - SHREG loads W = MUTE ? 0 : the new CUR, and I2S_DATA = W[15].
  - b==16: SHREG reloads W from the current CUR/MUTE, and I2S_DATA = W[15].
  - Other b: SHREG shifts left, and I2S_DATA = the next bit.
  - I2S_LRCK = 1 for b in 15..30, and 0 for b = 31 and 0..14. LRCK therefore leads the MSB by one bit, per I2S.
- Rising ticks change only I2S_BCLK.
- Simultaneous write and pop in one cycle: both are performed and FIFO_LEVEL is unchanged. A write to a full FIFO coinciding with a pop is accepted.
- Flags: CLR_FLAGS clears OVERFLOW/UNDERFLOW. A set event in the same cycle wins.

## Timing
- Reset values:
  - I2S_BCLK=0, I2S_LRCK=0, I2S_DATA=0, BIT_IDX=31, DIV_CNT=BCLK_DIV-1.
  - FIFO empty, FIFO_LEVEL=0, CUR=0, SHREG=0, PRIMED=0, OVERFLOW=0, UNDERFLOW=0.
- The first rising tick occurs BCLK_DIV cycles after reset release. The first falling tick (b=0) occurs at 2·BCLK_DIV.
- Write latency: FIFO_LEVEL updates the cycle after SAMP_VALID. The sample is transmitted at the next b==0 edge.
- All outputs are registered. I2S_DATA and I2S_LRCK change only on falling ticks, so they are stable at BCLK rising edges.
- Reset mid-frame: all state returns to reset values immediately (asynchronous) and buffered samples are discarded.
- FIFO pointers wrap modulo FIFO_DEPTH. The full/empty distinction uses the extra level bit.

## Structure
- Package pcm_out_pkg: IN_W=21, OUT_W=16, FRAME_BITS=32, the LRCK window bounds, and a function sat16(logic signed [20:0], shift).
- Sub-module pcm_fifo: synchronous FIFO, parameter DEPTH, 16-bit data, push/pop/full/empty/level. The top level holds the divider, bit counter, shifter and flags.

## Test plan
- Saturate: SHIFT=4, SAMP_IN=+600000 → word 0x7FFF; SAMP_IN=-600000 → 0x8000; SAMP_IN=0x00120 → 0x0012. All checked on I2S_DATA.
- Frame format: one sample 0xA5C3.
  - LRCK falls one BCLK before the left MSB.
  - 0xA5C3 is sent in both left and right slots, MSB first.
  - 32 BCLK periods per frame; BCLK period = 2·BCLK_DIV CLK cycles.
- Overflow: 5 strobes before the first b==0 with FIFO_DEPTH=4 → FIFO_LEVEL=4, 5th dropped, OVERFLOW=1. CLR_FLAGS → 0.
- Underflow: after one sample, no further writes → next frame repeats the last word and UNDERFLOW=1. Before any write: zeros and UNDERFLOW=0.
- Simultaneous: SAMP_VALID in the same cycle as the b==0 pop with FIFO_LEVEL=4 → write accepted, level stays 4, OVERFLOW=0.
- Mute and reset: MUTE=1 → zero words while FIFO_LEVEL still decrements per frame. RESET_N pulsed mid-word → all outputs and FIFO_LEVEL return to 0 at once.

Source files
------------

// File: rtl/pcm_out_pkg.sv
// pcm_out_pkg: shared widths, frame geometry and the ingest saturator for pcm_i2s_tx.
// Exports IN_W/OUT_W/FRAME_BITS, the LRCK-high bit window and sat16().
package pcm_out_pkg;
   localparam int IN_W       = 21;
   localparam int OUT_W      = 16;
   localparam int FRAME_BITS = 32;
   localparam int BIT_W      = $clog2(FRAME_BITS);
   localparam logic [BIT_W-1:0] LRCK_LO = 5'd15;
   localparam logic [BIT_W-1:0] LRCK_HI = 5'd30;

   function automatic logic signed [OUT_W-1:0] sat16(input logic signed [IN_W-1:0] s, input int shift);
      logic signed [IN_W-1:0] x;
      x = s >>> shift;
      return (x > 21'sd32767) ? 16'sh7FFF : (x < -21'sd32768) ? 16'sh8000 : x[OUT_W-1:0];
   endfunction
endpackage

// File: rtl/pcm_i2s_tx_if.sv
// pcm_i2s_tx_if: sample input, control and I2S/status bundle for pcm_i2s_tx.
// master = voice engine / controller side, slave = the transmitter.
// SAMP_IN/SAMP_VALID sample strobe, MUTE, CLR_FLAGS; I2S_BCLK/LRCK/DATA, FIFO_LEVEL, OVERFLOW, UNDERFLOW.
interface pcm_i2s_tx_if
   import pcm_out_pkg::*;
#(
   parameter int FIFO_DEPTH = 4
);
   logic signed [IN_W-1:0]         SAMP_IN;
   logic                           SAMP_VALID;
   logic                           MUTE;
   logic                           CLR_FLAGS;
   logic                           I2S_BCLK;
   logic                           I2S_LRCK;
   logic                           I2S_DATA;
   logic [$clog2(FIFO_DEPTH):0]    FIFO_LEVEL;
   logic                           OVERFLOW;
   logic                           UNDERFLOW;

   modport master (
      output SAMP_IN, SAMP_VALID, MUTE, CLR_FLAGS,
      input  I2S_BCLK, I2S_LRCK, I2S_DATA, FIFO_LEVEL, OVERFLOW, UNDERFLOW
   );
   modport slave (
      input  SAMP_IN, SAMP_VALID, MUTE, CLR_FLAGS,
      output I2S_BCLK, I2S_LRCK, I2S_DATA, FIFO_LEVEL, OVERFLOW, UNDERFLOW
   );
endinterface

// File: rtl/pcm_fifo.sv
// pcm_fifo: synchronous first-word-fall-through FIFO of 16-bit samples.
// Ports: CLK, RESET_N (async, active-low), push/wdata, pop/rdata, full, empty, level (registered occupancy).
module pcm_fifo #(
   parameter int DEPTH = 4
) (
   input  logic                     CLK,
   input  logic                     RESET_N,
   input  logic                     push,
   input  logic                     pop,
   input  logic [15:0]              wdata,
   output logic [15:0]              rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);
   localparam int AW = $clog2(DEPTH);
   logic [15:0]   mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   always_comb begin
      rdata = mem[rd_ptr];
      full  = level == (AW+1)'(DEPTH);
      empty = level == '0;
   end
   always_ff @(posedge CLK or negedge RESET_N)
      if (!RESET_N) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop) rd_ptr <= rd_ptr + AW'(1);
         if (push != pop) level <= push ? level + (AW+1)'(1) : level - (AW+1)'(1);
      end
   always_ff @(posedge CLK)
      if (push) mem[wr_ptr] <= wdata;
endmodule

// File: rtl/pcm_i2s_tx.sv
// pcm_i2s_tx: scales/saturates mono samples into a FIFO and serialises them as stereo I2S.
// Ports: CLK, RESET_N (async, active-low), bus (pcm_i2s_tx_if.slave: sample strobe, MUTE,
// CLR_FLAGS in; BCLK/LRCK/DATA, FIFO_LEVEL, sticky OVERFLOW/UNDERFLOW out).
module pcm_i2s_tx
   import pcm_out_pkg::*;
#(
   parameter int BCLK_DIV   = 4,
   parameter int FIFO_DEPTH = 4,
   parameter int SHIFT      = 4
) (
   input logic          CLK,
   input logic          RESET_N,
   pcm_i2s_tx_if.slave  bus
);
   localparam int DW = BCLK_DIV > 1 ? $clog2(BCLK_DIV) : 1;
   localparam int LW = $clog2(FIFO_DEPTH) + 1;
   logic [DW-1:0]    div_cnt;
   logic [BIT_W-1:0] bit_idx, b;
   logic [OUT_W-1:0] cur, cur_nxt, shreg, w, fifo_q;
   logic [LW-1:0]    level;
   logic bclk, lrck, data, primed, ovf, udf;
   logic tick, fall, frame_start, push, pop, full, empty;

   pcm_fifo #(.DEPTH(FIFO_DEPTH)) fifo (
      .CLK(CLK), .RESET_N(RESET_N), .push(push), .pop(pop),
      .wdata(sat16(bus.SAMP_IN, SHIFT)), .rdata(fifo_q),
      .full(full), .empty(empty), .level(level)
   );

   // A pop frees a slot on the same edge, so a write to a full FIFO is kept when it coincides with a pop.
   always_comb begin
      tick        = div_cnt == '0;
      fall        = tick && bclk;
      b           = bit_idx + BIT_W'(1);
      frame_start = fall && b == '0;
      pop         = frame_start && !empty;
      push        = bus.SAMP_VALID && (!full || pop);
      cur_nxt     = frame_start ? (!empty ? fifo_q : primed ? cur : '0) : cur;
      w           = bus.MUTE ? '0 : cur_nxt;
   end

   always_ff @(posedge CLK or negedge RESET_N)
      if (!RESET_N) begin
         div_cnt <= DW'(BCLK_DIV - 1);
         bit_idx <= '1;
         bclk    <= 1'b0;
         lrck    <= 1'b0;
         data    <= 1'b0;
         cur     <= '0;
         shreg   <= '0;
         primed  <= 1'b0;
         ovf     <= 1'b0;
         udf     <= 1'b0;
      end else begin
         div_cnt <= tick ? DW'(BCLK_DIV - 1) : div_cnt - DW'(1);
         if (tick) bclk <= !bclk;
         if (fall) begin
            bit_idx <= b;
            cur     <= cur_nxt;
            lrck    <= b >= LRCK_LO && b <= LRCK_HI;
            // Each slot restarts from the held word so left and right carry the same sample.
            shreg   <= (b == '0 || b == 5'd16) ? w : shreg << 1;
            data    <= (b == '0 || b == 5'd16) ? w[OUT_W-1] : shreg[OUT_W-2];
         end
         if (push) primed <= 1'b1;
         ovf <= (bus.SAMP_VALID && full && !pop) || (ovf && !bus.CLR_FLAGS);
         udf <= (frame_start && empty && primed) || (udf && !bus.CLR_FLAGS);
      end

   always_comb begin
      bus.I2S_BCLK   = bclk;
      bus.I2S_LRCK   = lrck;
      bus.I2S_DATA   = data;
      bus.FIFO_LEVEL = level;
      bus.OVERFLOW   = ovf;
      bus.UNDERFLOW  = udf;
   end
endmodule

// File: tb/tb_pcm_i2s_tx.sv
// tb_pcm_i2s_tx: directed self-checking bench for pcm_i2s_tx with a queue model of the sample FIFO.
module tb_pcm_i2s_tx;
   localparam int BD = 4;
   localparam int FD = 4;
   localparam int SH = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [4:0] tb_bit = 5'd31;
   logic pb = 1'b0, cb = 1'b0;
   int cyc = 0, checks = 0, passes = 0;
   logic [15:0] q[$];
   logic [15:0] cur_m = 16'h0;

   pcm_i2s_tx_if #(.FIFO_DEPTH(FD)) bus ();
   pcm_i2s_tx #(.BCLK_DIV(BD), .FIFO_DEPTH(FD), .SHIFT(SH)) dut (.CLK(clk), .RESET_N(rst_n), .bus(bus));

   always #5 clk = ~clk;

   // Independent bit position: counts BCLK falling edges since reset.
   always @(negedge bus.I2S_BCLK or negedge rst_n)
      if (!rst_n) tb_bit <= 5'd31;
      else tb_bit <= tb_bit + 5'd1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   task automatic step();
      pb = cb;
      @(posedge clk);
      #1;
      cb = bus.I2S_BCLK;
      cyc++;
   endtask

   function automatic logic [15:0] m_sat(input int v);
      int x;
      x = v >>> SH;
      if (x > 32767) x = 32767;
      if (x < -32768) x = -32768;
      return x[15:0];
   endfunction

   task automatic write_samp(input int v);
      bus.SAMP_IN = 21'(v);
      bus.SAMP_VALID = 1'b1;
      step();
      bus.SAMP_VALID = 1'b0;
      if (q.size() < FD) q.push_back(m_sat(v));
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      step();
      step();
      rst_n = 1'b1;
      q.delete();
      cur_m = 16'h0;
   endtask

   task automatic check_frame(input string tag, input logic exp_udf);
      logic [31:0] bits;
      logic [15:0] exp;
      int n, lr_bad, per_bad, t_last;
      bits = '0;
      lr_bad = 0;
      per_bad = 0;
      n = 0;
      do begin step(); n++; end while (!(pb && !cb && tb_bit == 5'd0) && n < 1000);
      chk({tag, "_start"}, 32'(n < 1000), 32'd1);
      if (q.size() > 0) cur_m = q.pop_front();
      exp = bus.MUTE ? 16'h0 : cur_m;
      t_last = cyc;
      for (int i = 0; i < 32; i++) begin
         n = 0;
         do begin step(); n++; end while (!(!pb && cb) && n < 100);
         if (cyc - t_last != (i == 0 ? BD : 2 * BD)) per_bad++;
         t_last = cyc;
         bits[31-i] = bus.I2S_DATA;
         if (bus.I2S_LRCK !== (i >= 15 && i <= 30)) lr_bad++;
      end
      chk({tag, "_left"}, 32'(bits[31:16]), 32'(exp));
      chk({tag, "_right"}, 32'(bits[15:0]), 32'(exp));
      chk({tag, "_lrck"}, 32'(lr_bad), 32'd0);
      chk({tag, "_period"}, 32'(per_bad), 32'd0);
      chk({tag, "_udf"}, 32'(bus.UNDERFLOW), 32'(exp_udf));
   endtask

   initial begin
      int n;
      bus.SAMP_IN = '0;
      bus.SAMP_VALID = 1'b0;
      bus.MUTE = 1'b0;
      bus.CLR_FLAGS = 1'b0;
      step();
      step();
      chk("rst_bclk", 32'(bus.I2S_BCLK), 32'd0);
      chk("rst_lrck", 32'(bus.I2S_LRCK), 32'd0);
      chk("rst_data", 32'(bus.I2S_DATA), 32'd0);
      chk("rst_level", 32'(bus.FIFO_LEVEL), 32'd0);
      chk("rst_ovf", 32'(bus.OVERFLOW), 32'd0);
      chk("rst_udf", 32'(bus.UNDERFLOW), 32'd0);
      rst_n = 1'b1;
      n = 0;
      do begin step(); n++; end while (!(!pb && cb) && n < 100);
      chk("first_rise", 32'(n), 32'(BD));
      check_frame("idle", 1'b0);
      write_samp(-23101 * 16);
      chk("lvl_after_write", 32'(bus.FIFO_LEVEL), 32'd1);
      check_frame("a5c3", 1'b0);
      check_frame("repeat", 1'b1);
      bus.CLR_FLAGS = 1'b1;
      step();
      bus.CLR_FLAGS = 1'b0;
      chk("udf_clr", 32'(bus.UNDERFLOW), 32'd0);

      do_reset();
      write_samp(600000);
      write_samp('h12340);
      write_samp(-600000);
      write_samp('h120);
      write_samp('h5670);
      chk("ovf_level", 32'(bus.FIFO_LEVEL), 32'd4);
      chk("ovf_set", 32'(bus.OVERFLOW), 32'd1);
      bus.CLR_FLAGS = 1'b1;
      step();
      bus.CLR_FLAGS = 1'b0;
      chk("ovf_clr", 32'(bus.OVERFLOW), 32'd0);
      check_frame("sat_pos", 1'b0);
      write_samp('h3210);
      chk("sim_pre_level", 32'(bus.FIFO_LEVEL), 32'd4);
      step();
      step();
      bus.SAMP_IN = 21'(-4096);
      bus.SAMP_VALID = 1'b1;
      step();
      bus.SAMP_VALID = 1'b0;
      chk("sim_align", 32'(pb && !cb && tb_bit == 5'd0), 32'd1);
      cur_m = q.pop_front();
      q.push_back(m_sat(-4096));
      chk("sim_level", 32'(bus.FIFO_LEVEL), 32'd4);
      chk("sim_ovf", 32'(bus.OVERFLOW), 32'd0);
      check_frame("sat_neg", 1'b0);
      check_frame("sat_small", 1'b0);
      check_frame("after_sim", 1'b0);
      check_frame("sim_word", 1'b0);
      check_frame("underflow", 1'b1);

      write_samp('h7FFF0);
      write_samp('h55550);
      write_samp('h1110);
      bus.MUTE = 1'b1;
      check_frame("mute", 1'b1);
      chk("mute_level", 32'(bus.FIFO_LEVEL), 32'd2);
      bus.MUTE = 1'b0;
      n = 0;
      do begin step(); n++; end while (!(!pb && cb && tb_bit == 5'd1) && n < 1000);
      chk("pre_rst_data", 32'(bus.I2S_DATA), 32'd1);
      chk("pre_rst_level", 32'(bus.FIFO_LEVEL), 32'd1);
      #3;
      rst_n = 1'b0;
      #1;
      chk("arst_bclk", 32'(bus.I2S_BCLK), 32'd0);
      chk("arst_lrck", 32'(bus.I2S_LRCK), 32'd0);
      chk("arst_data", 32'(bus.I2S_DATA), 32'd0);
      chk("arst_level", 32'(bus.FIFO_LEVEL), 32'd0);
      chk("arst_udf", 32'(bus.UNDERFLOW), 32'd0);
      chk("arst_ovf", 32'(bus.OVERFLOW), 32'd0);
      step();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
